// File: rtl/regffte_mel_reader.sv
// Read-side controller for the FFT-energy register file.
// Walks the triangular mel filter bank: fetches filter edges from a
// synchronous edge ROM, then streams bins lo..hi of each filter out of
// regffte to the mel accumulator with filter index, first/last and slope tags.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for addmel_en
// LD_LO  | fetching e[0] (lower edge of filter 0)
// LD_CTR | fetching e[1] (centre of filter 0)
// LD_HI  | fetching e[f+2] (upper edge of filter f), then validating edges
// SCAN   | issuing one regffte read per cycle, ptr = lo..hi
// FLUSH  | draining the read pipeline before pulsing done
module regffte_mel_reader #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16,
    parameter int NFILT  = 20,
    parameter int FIDX_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              addmel_en,
    output logic [FIDX_W-1:0] edge_addr,
    input  logic [ADDR_W-1:0] edge_q,
    output logic              regffte_rden,
    output logic [ADDR_W-1:0] regffte_addr,
    input  logic [DATA_W-1:0] regffte_q,
    output logic              bin_valid,
    output logic [DATA_W-1:0] bin_data,
    output logic [ADDR_W-1:0] bin_addr,
    output logic [FIDX_W-1:0] filt_idx,
    output logic              filt_first,
    output logic              filt_last,
    output logic              up_slope,
    output logic              busy,
    output logic              done,
    output logic              edge_err
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LD_LO  = 3'd1;
    localparam logic [2:0] LD_CTR = 3'd2;
    localparam logic [2:0] LD_HI  = 3'd3;
    localparam logic [2:0] SCAN   = 3'd4;
    localparam logic [2:0] FLUSH  = 3'd5;

    logic [2:0]        state;
    logic              phase;
    logic [ADDR_W-1:0] lo, ctr, hi, ptr;
    logic [FIDX_W-1:0] f;

    logic              s1_valid;
    logic [ADDR_W-1:0] s1_addr;
    logic [FIDX_W-1:0] s1_fidx;
    logic              s1_first, s1_last, s1_up;

    logic              edges_bad;
    logic              go_next;
    logic [ADDR_W-1:0] next_hi;

    // ptr only moves on SCAN entry and during SCAN, so it doubles as the held read address
    assign regffte_rden = (state == SCAN);
    assign regffte_addr = ptr;

    // Decide when the current filter is finished (scanned out or rejected)
    always_comb begin
        edges_bad = (edge_q < lo) || (ctr < lo) || (ctr > edge_q);
        go_next   = 1'b0;
        next_hi   = hi;
        if (state == LD_HI && phase && edges_bad) begin
            go_next = 1'b1;
            next_hi = edge_q;
        end else if (state == SCAN && ptr == hi) begin
            go_next = 1'b1;
        end
    end

    // Sequencer: edge fetches take two cycles each (registered address, registered ROM)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            phase     <= 1'b0;
            lo        <= '0;
            ctr       <= '0;
            hi        <= '0;
            ptr       <= '0;
            f         <= '0;
            edge_addr <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            edge_err  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (addmel_en) begin
                        edge_err  <= 1'b0;
                        busy      <= 1'b1;
                        edge_addr <= '0;
                        f         <= '0;
                        phase     <= 1'b0;
                        state     <= LD_LO;
                    end
                end
                LD_LO: begin
                    phase <= ~phase;
                    if (phase) begin
                        lo        <= edge_q;
                        edge_addr <= FIDX_W'(1);
                        state     <= LD_CTR;
                    end
                end
                LD_CTR: begin
                    phase <= ~phase;
                    if (phase) begin
                        ctr       <= edge_q;
                        edge_addr <= f + FIDX_W'(2);
                        state     <= LD_HI;
                    end
                end
                LD_HI: begin
                    phase <= ~phase;
                    if (phase) begin
                        hi <= edge_q;
                        if (edges_bad) begin
                            edge_err <= 1'b1;
                        end else begin
                            ptr   <= lo;
                            state <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (ptr != hi) begin
                        ptr <= ptr + ADDR_W'(1);
                    end
                end
                FLUSH: begin
                    if (!s1_valid) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Filters share edges: this filter's centre/upper become the next one's lower/centre
            if (go_next) begin
                if (f == FIDX_W'(NFILT - 1)) begin
                    state <= FLUSH;
                end else begin
                    lo        <= ctr;
                    ctr       <= next_hi;
                    f         <= f + FIDX_W'(1);
                    edge_addr <= f + FIDX_W'(3);
                    phase     <= 1'b0;
                    state     <= LD_HI;
                end
            end
        end
    end

    // Two-stage output pipeline: tags wait one cycle for regffte_q, then everything registers together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_addr    <= '0;
            s1_fidx    <= '0;
            s1_first   <= 1'b0;
            s1_last    <= 1'b0;
            s1_up      <= 1'b0;
            bin_valid  <= 1'b0;
            bin_data   <= '0;
            bin_addr   <= '0;
            filt_idx   <= '0;
            filt_first <= 1'b0;
            filt_last  <= 1'b0;
            up_slope   <= 1'b0;
        end else begin
            s1_valid  <= (state == SCAN);
            bin_valid <= s1_valid;
            if (state == SCAN) begin
                s1_addr  <= ptr;
                s1_fidx  <= f;
                s1_first <= (ptr == lo);
                s1_last  <= (ptr == hi);
                s1_up    <= (ptr < ctr);
            end
            if (s1_valid) begin
                bin_data   <= regffte_q;
                bin_addr   <= s1_addr;
                filt_idx   <= s1_fidx;
                filt_first <= s1_first;
                filt_last  <= s1_last;
                up_slope   <= s1_up;
            end
        end
    end

endmodule
